riscv_decode_stage: RTL and testbench

//  Parametrised ID stage for RV32I/RV64I: field extraction, full immediate generation (I/S/B/U/J),

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/riscv_imm_gen.sv | 30 +++
 rtl/riscv_decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcodes, immediate formats,
// ALU operation classes and the bundle of decoded control bits.
package riscv_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic      alu_src;
    logic      mem_to_reg;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      illegal;
    logic      uses_rs1;
    logic      uses_rs2;
    alu_op_e   alu_op;
    imm_type_e imm_type;
  } ctrl_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: assembles the I/S/B/U/J immediate from the
// instruction word and sign-extends it from bit 31 to XLEN.
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;

  // Format-specific bit scatter into a 32-bit sign-extended immediate
  always_comb begin
    imm32_s = 32'd0;
    case (imm_type)
      IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32_s = {instr[31:12], 12'd0};
      IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/riscv_decode_stage.sv
// ID stage: decodes the instruction in IF/ID, detects load-use hazards and
// holds the decoded result in a valid/ready handshaked ID/EX register.
module riscv_decode_stage #(
  parameter int XLEN          = 32,
  parameter int REGFILE_COUNT = 32,
  localparam int RW           = $clog2(REGFILE_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [RW-1:0]   rs1_o,
  output logic [RW-1:0]   rs2_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ex_mem_read_i,
  input  logic [RW-1:0]   ex_rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [RW-1:0]   rs1_idx_o,
  output logic [RW-1:0]   rs2_idx_o,
  output logic [RW-1:0]   rd_o,
  output logic            alu_src_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic [1:0]      alu_op_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            illegal_o
);

  import riscv_pkg::*;

  opcode_e         opcode_s;
  ctrl_t           ctrl_s;
  logic [RW-1:0]   rd_s;
  logic [XLEN-1:0] imm_s;
  logic            hazard_s;
  logic            load_s;
  logic            accept_s;

  assign opcode_s = opcode_e'(instr_i[6:0]);
  assign rs1_o    = RW'(instr_i[19:15]);
  assign rs2_o    = RW'(instr_i[24:20]);
  assign rd_s     = RW'(instr_i[11:7]);

  // Opcode to control bits, immediate format and register-use flags
  always_comb begin
    ctrl_s = '0;
    case (opcode_s)
      OPC_LOAD: begin
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.uses_rs1   = 1'b1;
        ctrl_s.imm_type   = IMM_I;
      end
      OPC_STORE: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.mem_write = 1'b1;
        ctrl_s.uses_rs1  = 1'b1;
        ctrl_s.uses_rs2  = 1'b1;
        ctrl_s.imm_type  = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl_s.branch   = 1'b1;
        ctrl_s.alu_op   = ALU_BRANCH;
        ctrl_s.uses_rs1 = 1'b1;
        ctrl_s.uses_rs2 = 1'b1;
        ctrl_s.imm_type = IMM_B;
      end
      OPC_JAL: begin
        ctrl_s.jump      = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.imm_type  = IMM_J;
      end
      OPC_JALR: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.jump      = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.uses_rs1  = 1'b1;
        ctrl_s.imm_type  = IMM_I;
      end
      OPC_OP_IMM: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_ITYPE;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.uses_rs1  = 1'b1;
        ctrl_s.imm_type  = IMM_I;
      end
      OPC_OP: begin
        ctrl_s.alu_op    = ALU_RTYPE;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.uses_rs1  = 1'b1;
        ctrl_s.uses_rs2  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.imm_type  = IMM_U;
      end
      default: begin
        // Unknown opcodes still read rs1 for hazard purposes
        ctrl_s.illegal  = 1'b1;
        ctrl_s.uses_rs1 = 1'b1;
      end
    endcase
  end

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (instr_i),
    .imm_type (ctrl_s.imm_type),
    .imm      (imm_s)
  );

  assign hazard_s = valid_i & ex_mem_read_i & (ex_rd_i != {RW{1'b0}}) &
                    ((ctrl_s.uses_rs1 & (ex_rd_i == rs1_o)) |
                     (ctrl_s.uses_rs2 & (ex_rd_i == rs2_o)));
  assign load_s   = ~valid_o | ready_i;
  assign accept_s = valid_i & ~hazard_s;
  assign ready_o  = load_s & ~hazard_s;

  // ID/EX register: reset, then flush, then load (bubble on hazard), else hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      pc_o         <= {XLEN{1'b0}};
      imm_o        <= {XLEN{1'b0}};
      rs1_data_o   <= {XLEN{1'b0}};
      rs2_data_o   <= {XLEN{1'b0}};
      rs1_idx_o    <= {RW{1'b0}};
      rs2_idx_o    <= {RW{1'b0}};
      rd_o         <= {RW{1'b0}};
      alu_src_o    <= 1'b0;
      mem_to_reg_o <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      branch_o     <= 1'b0;
      jump_o       <= 1'b0;
      alu_op_o     <= 2'b00;
      funct3_o     <= 3'd0;
      funct7_o     <= 7'd0;
      illegal_o    <= 1'b0;
    end else if (flush_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      branch_o    <= 1'b0;
      jump_o      <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (load_s) begin
      valid_o      <= accept_s;
      pc_o         <= pc_i;
      imm_o        <= imm_s;
      rs1_data_o   <= rs1_data_i;
      rs2_data_o   <= rs2_data_i;
      rs1_idx_o    <= rs1_o;
      rs2_idx_o    <= rs2_o;
      rd_o         <= rd_s;
      alu_src_o    <= ctrl_s.alu_src;
      mem_to_reg_o <= ctrl_s.mem_to_reg;
      reg_write_o  <= ctrl_s.reg_write & accept_s & (rd_s != {RW{1'b0}});
      mem_read_o   <= ctrl_s.mem_read & accept_s;
      mem_write_o  <= ctrl_s.mem_write & accept_s;
      branch_o     <= ctrl_s.branch & accept_s;
      jump_o       <= ctrl_s.jump & accept_s;
      alu_op_o     <= ctrl_s.alu_op;
      funct3_o     <= instr_i[14:12];
      funct7_o     <= instr_i[31:25];
      illegal_o    <= ctrl_s.illegal & accept_s;
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are compared every cycle against an arithmetic reference model of the stage.
module tb_riscv_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_i, ready_i, flush, ex_mr;
  logic [4:0]  ex_rd;
  logic [31:0] instr;
  logic [63:0] pc, a, b;

  logic        r32, v32, as32, m2r32, rw32, mr32, mw32, br32, j32, il32;
  logic [4:0]  s1_32, s2_32, i1_32, i2_32, rd32;
  logic [31:0] pc32, imm32, a32, b32;
  logic [1:0]  op32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;

  logic        r64, v64, as64, m2r64, rw64, mr64, mw64, br64, j64, il64;
  logic [4:0]  s1_64, s2_64, i1_64, i2_64, rd64;
  logic [63:0] pc64, imm64, a64, b64;
  logic [1:0]  op64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;

  riscv_decode_stage #(.XLEN(32), .REGFILE_COUNT(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r32), .pc_i(pc[31:0]),
    .instr_i(instr), .rs1_o(s1_32), .rs2_o(s2_32), .rs1_data_i(a[31:0]), .rs2_data_i(b[31:0]),
    .ex_mem_read_i(ex_mr), .ex_rd_i(ex_rd), .flush_i(flush), .valid_o(v32), .ready_i(ready_i),
    .pc_o(pc32), .imm_o(imm32), .rs1_data_o(a32), .rs2_data_o(b32), .rs1_idx_o(i1_32),
    .rs2_idx_o(i2_32), .rd_o(rd32), .alu_src_o(as32), .mem_to_reg_o(m2r32), .reg_write_o(rw32),
    .mem_read_o(mr32), .mem_write_o(mw32), .branch_o(br32), .jump_o(j32), .alu_op_o(op32),
    .funct3_o(f3_32), .funct7_o(f7_32), .illegal_o(il32));

  riscv_decode_stage #(.XLEN(64), .REGFILE_COUNT(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r64), .pc_i(pc),
    .instr_i(instr), .rs1_o(s1_64), .rs2_o(s2_64), .rs1_data_i(a), .rs2_data_i(b),
    .ex_mem_read_i(ex_mr), .ex_rd_i(ex_rd), .flush_i(flush), .valid_o(v64), .ready_i(ready_i),
    .pc_o(pc64), .imm_o(imm64), .rs1_data_o(a64), .rs2_data_o(b64), .rs1_idx_o(i1_64),
    .rs2_idx_o(i2_64), .rd_o(rd64), .alu_src_o(as64), .mem_to_reg_o(m2r64), .reg_write_o(rw64),
    .mem_read_o(mr64), .mem_write_o(mw64), .branch_o(br64), .jump_o(j64), .alu_op_o(op64),
    .funct3_o(f3_64), .funct7_o(f7_64), .illegal_o(il64));

  typedef struct packed {
    logic src, m2r, rw, mr, mw, br, j;
    logic [1:0] op;
    logic ill;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc, imm, a, b;
    logic [4:0]  i1, i2, rd;
    ctl_t        c;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  exp_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate as a signed number computed from its field width
  function automatic logic [63:0] ref_imm(input logic [31:0] ins);
    longint v;
    v = 0;
    case (ins[6:0])
      7'h03, 7'h67, 7'h13: begin v = longint'(ins[31:20]); if (ins[31]) v -= 4096; end
      7'h23: begin v = longint'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 4096; end
      7'h63: begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        if (ins[31]) v -= 8192;
      end
      7'h37, 7'h17: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= 64'h1_0000_0000; end
      7'h6F: begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        if (ins[31]) v -= 2097152;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // Control table: src m2r rw mr mw br j op[1:0] ill
  function automatic ctl_t ref_ctl(input logic [6:0] op);
    case (op)
      7'h03:        return 10'b1111000000;
      7'h23:        return 10'b1000100000;
      7'h63:        return 10'b0000010010;
      7'h6F:        return 10'b0010001000;
      7'h67:        return 10'b1010001000;
      7'h13:        return 10'b1010000110;
      7'h33:        return 10'b0010000100;
      7'h37, 7'h17: return 10'b1010000000;
      default:      return 10'b0000000001;
    endcase
  endfunction

  function automatic logic ref_hazard();
    logic u1, u2;
    u1 = !(instr[6:0] == 7'h37 || instr[6:0] == 7'h17 || instr[6:0] == 7'h6F);
    u2 = (instr[6:0] == 7'h33 || instr[6:0] == 7'h23 || instr[6:0] == 7'h63);
    return valid_i && ex_mr && ex_rd != 5'd0 &&
           ((u1 && ex_rd == instr[19:15]) || (u2 && ex_rd == instr[24:20]));
  endfunction

  task automatic check_regs();
    chk("valid32", 64'(v32), 64'(m.valid));      chk("valid64", 64'(v64), 64'(m.valid));
    chk("pc32", 64'(pc32), 64'(m.pc[31:0]));     chk("pc64", pc64, m.pc);
    chk("imm32", 64'(imm32), 64'(m.imm[31:0]));  chk("imm64", imm64, m.imm);
    chk("a32", 64'(a32), 64'(m.a[31:0]));        chk("a64", a64, m.a);
    chk("b32", 64'(b32), 64'(m.b[31:0]));        chk("b64", b64, m.b);
    chk("idx32", 64'({i1_32, i2_32, rd32}), 64'({m.i1, m.i2, m.rd}));
    chk("idx64", 64'({i1_64, i2_64, rd64}), 64'({m.i1, m.i2, m.rd}));
    chk("ctl32", 64'({as32, m2r32, rw32, mr32, mw32, br32, j32, op32, il32}), 64'(m.c));
    chk("ctl64", 64'({as64, m2r64, rw64, mr64, mw64, br64, j64, op64, il64}), 64'(m.c));
    chk("funct32", 64'({f3_32, f7_32}), 64'({m.f3, m.f7}));
    chk("funct64", 64'({f3_64, f7_64}), 64'({m.f3, m.f7}));
  endtask

  // One clock: combinational checks, model step, registered checks
  task automatic cycle(input bit comb_chk);
    exp_t n;
    ctl_t c;
    logic hz, acc;
    #1;
    hz = ref_hazard();
    if (comb_chk) begin
      chk("ready32", 64'(r32), 64'((!m.valid || ready_i) && !hz));
      chk("ready64", 64'(r64), 64'((!m.valid || ready_i) && !hz));
      chk("rs32", 64'({s1_32, s2_32}), 64'({instr[19:15], instr[24:20]}));
      chk("rs64", 64'({s1_64, s2_64}), 64'({instr[19:15], instr[24:20]}));
    end
    n = m;
    if (rst) begin
      n = '0;
    end else if (flush) begin
      n.valid = 1'b0;
      {n.c.rw, n.c.mr, n.c.mw, n.c.br, n.c.j, n.c.ill} = 6'b0;
    end else if (!m.valid || ready_i) begin
      c   = ref_ctl(instr[6:0]);
      acc = valid_i && !hz;
      n.valid = acc;
      n.pc = pc; n.imm = ref_imm(instr); n.a = a; n.b = b;
      n.i1 = instr[19:15]; n.i2 = instr[24:20]; n.rd = instr[11:7];
      n.f3 = instr[14:12]; n.f7 = instr[31:25];
      n.c.src = c.src; n.c.m2r = c.m2r; n.c.op = c.op;
      n.c.rw  = c.rw && acc && instr[11:7] != 5'd0;
      n.c.mr  = c.mr && acc; n.c.mw = c.mw && acc; n.c.br = c.br && acc;
      n.c.j   = c.j && acc;  n.c.ill = c.ill && acc;
    end
    @(posedge clk);
    #1;
    m = n;
    check_regs();
    @(negedge clk);
  endtask

  logic [6:0]  opc [9] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17};
  logic [31:0] r;

  initial begin
    m = '0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
    instr = 32'h0; pc = 64'h0; a = 64'h0; b = 64'h0;
    @(negedge clk);
    cycle(1'b0);
    rst = 1'b0;

    // 1: addi x5,x1,-1
    valid_i = 1'b1; instr = 32'hFFF08293; pc = 64'h100; a = 64'h11; b = 64'h22;
    cycle(1'b1);
    chk("t1_valid", 64'(v32), 64'd1);
    chk("t1_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("t1_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("t1_rd", 64'(rd32), 64'd5);
    chk("t1_ctl", 64'({as32, op32, rw32}), 64'b1111);

    // 2: load-use hazard on add x3,x1,x2
    ex_mr = 1'b1; ex_rd = 5'd1; instr = 32'h002081B3; pc = 64'h104;
    #1 chk("t2_ready", 64'(r32), 64'd0);
    cycle(1'b1);
    chk("t2_bubble", 64'(v32), 64'd0);
    ex_mr = 1'b0;
    cycle(1'b1);
    chk("t2_accept", 64'({v32, rd32, op32}), 64'({1'b1, 5'd3, 2'b10}));

    // 3: beq x0,x0,-4 then lui x7,0x12345
    instr = 32'hFE000EE3; pc = 64'h108;
    cycle(1'b1);
    chk("t3_beq_imm32", 64'(imm32), 64'hFFFFFFFC);
    chk("t3_beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("t3_beq_ctl", 64'({br32, op32}), 64'b101);
    instr = 32'h123453B7; pc = 64'h10C;
    cycle(1'b1);
    chk("t3_lui", 64'({imm32, rw32}), 64'({32'h12345000, 1'b1}));

    // 4: stall for three cycles with changing input, then flush
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr = 32'h00A00513 + 32'(i); pc = 64'h200 + 64'(i);
      cycle(1'b1);
      chk("t4_hold_pc", 64'(pc32), 64'h10C);
      chk("t4_ready", 64'(r32), 64'd0);
    end
    flush = 1'b1;
    cycle(1'b1);
    chk("t4_flush", 64'({v32, rw32}), 64'd0);
    flush = 1'b0; ready_i = 1'b1;

    // 5: illegal opcode, then addi x0,x0,0
    instr = 32'h0000007F;
    cycle(1'b1);
    chk("t5_illegal", 64'({il32, as32, m2r32, rw32, mr32, mw32, br32, j32, op32}), 64'h200);
    instr = 32'h00000013;
    cycle(1'b1);
    chk("t5_x0_rw", 64'(rw32), 64'd0);

    // 6: reset while stalled with a valid instruction
    instr = 32'hFFF08293;
    cycle(1'b1);
    ready_i = 1'b0; rst = 1'b1;
    cycle(1'b1);
    chk("t6_reset", 64'({v32, v64, imm32, rw64}), 64'd0);
    rst = 1'b0; ready_i = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      instr = ($urandom_range(0, 9) == 0) ? r : {r[31:7], opc[$urandom_range(0, 8)]};
      if ($urandom_range(0, 1) == 1) begin
        instr[19:15] = 5'($urandom_range(0, 3));
        instr[24:20] = 5'($urandom_range(0, 3));
      end
      pc = {$urandom(), $urandom()}; a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      ex_mr   = ($urandom_range(0, 1) == 1);
      ex_rd   = 5'($urandom_range(0, 3));
      flush   = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
